// File: rtl/dmi_arbiter_if.sv
// DMI payload types and the bundle of request/response signals between the
// requesters, the arbiter and the debug module.

package dm;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// master is the arbiter's view; slave is the view of everything around it
// (the requesters plus the debug module).
interface dmi_arbiter_if #(
  parameter int NumReq = 2
);

  logic [NumReq-1:0]        req_valid_i;
  dm::dmi_req_t [NumReq-1:0] req_i;
  logic [NumReq-1:0]        req_ready_o;
  dm::dmi_resp_t            resp_o;
  logic [NumReq-1:0]        resp_valid_o;
  logic [NumReq-1:0]        resp_ready_i;
  dm::dmi_req_t             dmi_req_o;
  logic                     dmi_req_valid_o;
  logic                     dmi_req_ready_i;
  dm::dmi_resp_t            dmi_resp_i;
  logic                     dmi_resp_valid_i;
  logic                     dmi_resp_ready_o;

  modport master (
    input  req_valid_i, req_i, resp_ready_i,
    input  dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i,
    output req_ready_o, resp_o, resp_valid_o,
    output dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o
  );

  modport slave (
    output req_valid_i, req_i, resp_ready_i,
    output dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i,
    input  req_ready_o, resp_o, resp_valid_o,
    input  dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o
  );

endinterface

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DMI port of the debug module between
// NumReq transport masters, one outstanding transaction at a time, with an
// optional response timeout that returns an error and later swallows the
// late response.

module dmi_arbiter #(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  dmi_arbiter_if.master    bus,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [1:0] {
    Idle,
    Req,
    WaitResp,
    Resp
  } state_e;

  state_e        state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  dm::dmi_req_t  req_q, req_d;
  dm::dmi_resp_t resp_q, resp_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          drop_q, drop_d;

  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] cand;

  assign bus.dmi_req_o = req_q;
  assign bus.resp_o    = resp_q;
  assign busy_o        = (state_q != Idle) || drop_q;

  // Find the first valid requester at or after the round-robin pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = IdxW'((int'(ptr_q) + i) % NumReq);
      if (!pick_found && bus.req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and output decode; a pending drop keeps the downstream
  // response channel open in every state and blocks new grants.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    req_d   = req_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;

    bus.req_ready_o      = '0;
    bus.resp_valid_o     = '0;
    bus.dmi_req_valid_o  = 1'b0;
    bus.dmi_resp_ready_o = drop_q;
    timeout_o            = 1'b0;

    if (drop_q && bus.dmi_resp_valid_i) begin
      drop_d = 1'b0;
    end

    case (state_q)
      Idle: begin
        if (!drop_q && pick_found) begin
          bus.req_ready_o[pick_idx] = 1'b1;
          req_d   = bus.req_i[pick_idx];
          gnt_d   = pick_idx;
          state_d = Req;
        end
      end
      Req: begin
        bus.dmi_req_valid_o = 1'b1;
        if (bus.dmi_req_ready_i) begin
          cnt_d   = '0;
          state_d = WaitResp;
        end
      end
      WaitResp: begin
        bus.dmi_resp_ready_o = 1'b1;
        if (bus.dmi_resp_valid_i) begin
          resp_d  = bus.dmi_resp_i;
          state_d = Resp;
        end else if (TimeoutCycles > 0) begin
          if (cnt_q == CntW'(TimeoutCycles - 1)) begin
            resp_d    = '{data: 32'h0, resp: 2'h2};
            drop_d    = 1'b1;
            timeout_o = 1'b1;
            state_d   = Resp;
          end else if (cnt_q != {CntW{1'b1}}) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      Resp: begin
        bus.resp_valid_o[gnt_q] = 1'b1;
        if (bus.resp_ready_i[gnt_q]) begin
          ptr_d   = (gnt_q == IdxW'(NumReq - 1)) ? '0 : gnt_q + IdxW'(1);
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      gnt_q   <= '0;
      ptr_q   <= '0;
      req_q   <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter with two requesters and an 8-cycle timeout.

module tb_dmi_arbiter;

  logic clk;
  logic rst_n;
  logic busy;
  logic timeout;

  int checks;
  int errors;

  dm::dmi_req_t rq0;
  dm::dmi_req_t rq1;
  dm::dmi_req_t rs;

  dmi_arbiter_if #(.NumReq(2)) bus ();

  dmi_arbiter #(
    .NumReq(2),
    .TimeoutCycles(8)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus),
    .busy_o(busy),
    .timeout_o(timeout)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic dm::dmi_req_t mk_req(input logic [6:0] a, input logic [1:0] o,
                                          input logic [31:0] d);
    dm::dmi_req_t r;
    r.addr = a;
    r.op   = o;
    r.data = d;
    return r;
  endfunction

  function automatic dm::dmi_resp_t mk_resp(input logic [31:0] d, input logic [1:0] s);
    dm::dmi_resp_t r;
    r.data = d;
    r.resp = s;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " req_ready"}, 64'(bus.req_ready_o), 64'(2'b00));
    check_output({tag, " resp_valid"}, 64'(bus.resp_valid_o), 64'(2'b00));
    check_output({tag, " dmi_req_valid"}, 64'(bus.dmi_req_valid_o), 64'(1'b0));
    check_output({tag, " dmi_resp_ready"}, 64'(bus.dmi_resp_ready_o), 64'(1'b0));
    check_output({tag, " busy"}, 64'(busy), 64'(1'b0));
    check_output({tag, " timeout"}, 64'(timeout), 64'(1'b0));
    check_output({tag, " dmi_req"}, 64'(bus.dmi_req_o), 64'(0));
    check_output({tag, " resp"}, 64'(bus.resp_o), 64'(0));
  endtask

  // One complete transaction with both requesters valid; g is the expected grant.
  task automatic run_txn(input int g, input logic [31:0] d);
    logic [1:0] onehot;
    onehot    = '0;
    onehot[g] = 1'b1;
    #1;
    check_output("rr req_ready", 64'(bus.req_ready_o), 64'(onehot));
    tick();
    #1;
    check_output("rr dmi_req", 64'(bus.dmi_req_o), 64'((g == 1) ? rq1 : rq0));
    check_output("rr no regrant", 64'(bus.req_ready_o), 64'(2'b00));
    tick();
    bus.dmi_resp_i       = mk_resp(d, 2'h0);
    bus.dmi_resp_valid_i = 1'b1;
    tick();
    bus.dmi_resp_valid_i = 1'b0;
    #1;
    check_output("rr resp_valid", 64'(bus.resp_valid_o), 64'(onehot));
    check_output("rr resp", 64'(bus.resp_o), 64'(mk_resp(d, 2'h0)));
    tick();
  endtask

  // Linear sequence of directed steps.
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.req_valid_i      = '0;
    bus.req_i            = '0;
    bus.resp_ready_i     = '0;
    bus.dmi_req_ready_i  = 1'b0;
    bus.dmi_resp_i       = '0;
    bus.dmi_resp_valid_i = 1'b0;
    #2;
    check_reset_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // Single read from requester 0 with an immediate downstream response.
    bus.req_i[0]        = mk_req(7'h11, 2'd1, 32'h0);
    bus.req_valid_i     = 2'b01;
    bus.resp_ready_i    = 2'b01;
    bus.dmi_req_ready_i = 1'b1;
    #1;
    check_output("t1 req_ready", 64'(bus.req_ready_o), 64'(2'b01));
    check_output("t1 busy idle", 64'(busy), 64'(1'b0));
    tick();
    bus.req_valid_i = 2'b00;
    #1;
    check_output("t1 dmi_req_valid", 64'(bus.dmi_req_valid_o), 64'(1'b1));
    check_output("t1 dmi_req", 64'(bus.dmi_req_o), 64'(mk_req(7'h11, 2'd1, 32'h0)));
    check_output("t1 busy", 64'(busy), 64'(1'b1));
    tick();
    bus.dmi_resp_i       = mk_resp(32'hDEADBEEF, 2'h0);
    bus.dmi_resp_valid_i = 1'b1;
    #1;
    check_output("t1 dmi_resp_ready", 64'(bus.dmi_resp_ready_o), 64'(1'b1));
    check_output("t1 dmi_req_valid low", 64'(bus.dmi_req_valid_o), 64'(1'b0));
    tick();
    bus.dmi_resp_valid_i = 1'b0;
    #1;
    check_output("t1 resp_valid", 64'(bus.resp_valid_o), 64'(2'b01));
    check_output("t1 resp", 64'(bus.resp_o), 64'(mk_resp(32'hDEADBEEF, 2'h0)));
    tick();
    #1;
    check_output("t1 resp_valid done", 64'(bus.resp_valid_o), 64'(2'b00));
    check_output("t1 busy done", 64'(busy), 64'(1'b0));

    // Both requesters valid: pointer is now 1, so grants run 1,0,1,0,1,0.
    rq0 = mk_req(7'h20, 2'd2, 32'hA0A0_0000);
    rq1 = mk_req(7'h21, 2'd2, 32'hB1B1_0000);
    bus.req_i[0]     = rq0;
    bus.req_i[1]     = rq1;
    bus.req_valid_i  = 2'b11;
    bus.resp_ready_i = 2'b11;
    for (int k = 0; k < 6; k++) begin
      run_txn((k % 2 == 0) ? 1 : 0, 32'h1000_0000 + 32'(k));
    end
    bus.req_valid_i = 2'b00;

    // Downstream stalls for 5 cycles: request held, no new grant.
    rs = mk_req(7'h05, 2'd2, 32'hCAFE_0005);
    bus.req_i[0]        = rs;
    bus.req_valid_i     = 2'b01;
    bus.dmi_req_ready_i = 1'b0;
    #1;
    check_output("t3 req_ready", 64'(bus.req_ready_o), 64'(2'b01));
    tick();
    bus.req_valid_i = 2'b11;
    bus.req_i[0]    = mk_req(7'h7F, 2'd1, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_output("t3 stall valid", 64'(bus.dmi_req_valid_o), 64'(1'b1));
      check_output("t3 stall dmi_req", 64'(bus.dmi_req_o), 64'(rs));
      check_output("t3 stall no grant", 64'(bus.req_ready_o), 64'(2'b00));
      check_output("t3 stall busy", 64'(busy), 64'(1'b1));
      tick();
    end
    bus.req_valid_i     = 2'b00;
    bus.dmi_req_ready_i = 1'b1;
    tick();
    bus.dmi_resp_i       = mk_resp(32'h3333_0000, 2'h0);
    bus.dmi_resp_valid_i = 1'b1;
    tick();
    bus.dmi_resp_valid_i = 1'b0;
    #1;
    check_output("t3 resp_valid", 64'(bus.resp_valid_o), 64'(2'b01));
    check_output("t3 resp", 64'(bus.resp_o), 64'(mk_resp(32'h3333_0000, 2'h0)));
    tick();

    // Timeout: debug module never answers requester 1's read.
    bus.req_i[1]    = mk_req(7'h30, 2'd1, 32'h0);
    bus.req_valid_i = 2'b10;
    #1;
    check_output("t4 req_ready", 64'(bus.req_ready_o), 64'(2'b10));
    tick();
    bus.req_valid_i = 2'b00;
    tick();
    for (int i = 1; i < 8; i++) begin
      #1;
      check_output("t4 no early timeout", 64'(timeout), 64'(1'b0));
      tick();
    end
    #1;
    check_output("t4 timeout pulse", 64'(timeout), 64'(1'b1));
    tick();
    #1;
    check_output("t4 timeout one cycle", 64'(timeout), 64'(1'b0));
    check_output("t4 err resp_valid", 64'(bus.resp_valid_o), 64'(2'b10));
    check_output("t4 err resp", 64'(bus.resp_o), 64'(mk_resp(32'h0, 2'h2)));
    check_output("t4 drop ready", 64'(bus.dmi_resp_ready_o), 64'(1'b1));
    tick();
    bus.req_i[0]    = mk_req(7'h31, 2'd2, 32'h0000_0055);
    bus.req_valid_i = 2'b01;
    #1;
    check_output("t4 blocked", 64'(bus.req_ready_o), 64'(2'b00));
    check_output("t4 busy drop", 64'(busy), 64'(1'b1));
    check_output("t4 idle drop ready", 64'(bus.dmi_resp_ready_o), 64'(1'b1));
    tick();
    bus.dmi_resp_i       = mk_resp(32'hBAD0_BAD0, 2'h0);
    bus.dmi_resp_valid_i = 1'b1;
    #1;
    check_output("t4 blocked late", 64'(bus.req_ready_o), 64'(2'b00));
    tick();
    bus.dmi_resp_valid_i = 1'b0;
    #1;
    check_output("t4 late dropped", 64'(bus.resp_valid_o), 64'(2'b00));
    check_output("t4 grant resumes", 64'(bus.req_ready_o), 64'(2'b01));
    check_output("t4 busy clear", 64'(busy), 64'(1'b0));
    tick();
    bus.req_valid_i = 2'b00;
    #1;
    check_output("t4 next dmi_req", 64'(bus.dmi_req_o), 64'(mk_req(7'h31, 2'd2, 32'h0000_0055)));
    tick();
    bus.dmi_resp_i       = mk_resp(32'h4444_0000, 2'h0);
    bus.dmi_resp_valid_i = 1'b1;
    tick();
    bus.dmi_resp_valid_i = 1'b0;
    #1;
    check_output("t4 next resp", 64'(bus.resp_o), 64'(mk_resp(32'h4444_0000, 2'h0)));
    tick();

    // Response lands on the timeout cycle: real data wins.
    bus.req_i[0]    = mk_req(7'h32, 2'd1, 32'h0);
    bus.req_valid_i = 2'b01;
    #1;
    check_output("t5 req_ready", 64'(bus.req_ready_o), 64'(2'b01));
    tick();
    bus.req_valid_i = 2'b00;
    tick();
    for (int i = 1; i < 8; i++) begin
      tick();
    end
    bus.dmi_resp_i       = mk_resp(32'h600D_600D, 2'h0);
    bus.dmi_resp_valid_i = 1'b1;
    #1;
    check_output("t5 no timeout", 64'(timeout), 64'(1'b0));
    tick();
    bus.dmi_resp_valid_i = 1'b0;
    #1;
    check_output("t5 resp_valid", 64'(bus.resp_valid_o), 64'(2'b01));
    check_output("t5 real resp", 64'(bus.resp_o), 64'(mk_resp(32'h600D_600D, 2'h0)));
    tick();
    #1;
    check_output("t5 no drop busy", 64'(busy), 64'(1'b0));
    check_output("t5 no drop ready", 64'(bus.dmi_resp_ready_o), 64'(1'b0));

    // Asynchronous reset while waiting for a response.
    bus.req_i[1]    = mk_req(7'h40, 2'd2, 32'h1234_5678);
    bus.req_valid_i = 2'b10;
    #1;
    check_output("t6 req_ready", 64'(bus.req_ready_o), 64'(2'b10));
    tick();
    bus.req_valid_i = 2'b00;
    tick();
    #1;
    check_output("t6 waiting", 64'(bus.dmi_resp_ready_o), 64'(1'b1));
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6 async reset");
    tick();
    rst_n = 1'b1;
    bus.req_i[1]    = mk_req(7'h41, 2'd2, 32'hFEED_F00D);
    bus.req_valid_i = 2'b10;
    #1;
    check_output("t6 first grant", 64'(bus.req_ready_o), 64'(2'b10));
    tick();
    bus.req_valid_i = 2'b00;
    #1;
    check_output("t6 dmi_req", 64'(bus.dmi_req_o), 64'(mk_req(7'h41, 2'd2, 32'hFEED_F00D)));
    tick();
    bus.dmi_resp_i       = mk_resp(32'h7777_0000, 2'h0);
    bus.dmi_resp_valid_i = 1'b1;
    tick();
    bus.dmi_resp_valid_i = 1'b0;
    #1;
    check_output("t6 resp_valid", 64'(bus.resp_valid_o), 64'(2'b10));
    check_output("t6 resp", 64'(bus.resp_o), 64'(mk_resp(32'h7777_0000, 2'h0)));
    tick();
    #1;
    check_output("t6 idle", 64'(busy), 64'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
